// File: rtl/fft_pkg.sv
// fft_pkg: shared types, defaults and index helpers for the FFT datapath
//   DEFAULT_BUFFER_SIZE / DEFAULT_SAMPLE_SIZE : default frame length and sample width
//   sample_t        : signed sample at the default width
//   reorder_mode_e  : replay order selector
//   bit_reverse()   : reverses the low 'width' bits of idx
package fft_pkg;
    localparam int DEFAULT_BUFFER_SIZE = 32;
    localparam int DEFAULT_SAMPLE_SIZE = 32;
    typedef logic signed [DEFAULT_SAMPLE_SIZE-1:0] sample_t;
    typedef enum logic {
        REORDER_EVEN_ODD = 1'b0,
        REORDER_BITREV   = 1'b1
    } reorder_mode_e;
    function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < width) r[i] = idx[width-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_reorder_addr_gen.sv
// fft_reorder_addr_gen: maps an output index to its buffer address for a reorder mode
//   rd_idx_i : output-order index
//   mode_i   : even/odd split or full bit-reverse
//   addr_o   : buffer address holding the sample for rd_idx_i
//   odd_o    : sample belongs to the odd half (even/odd mode only)
module fft_reorder_addr_gen
    import fft_pkg::*;
#(
    parameter int BUFFER_SIZE = 32
) (
    input  logic [$clog2(BUFFER_SIZE)-1:0] rd_idx_i,
    input  reorder_mode_e                  mode_i,
    output logic [$clog2(BUFFER_SIZE)-1:0] addr_o,
    output logic                           odd_o
);
    localparam int AW = $clog2(BUFFER_SIZE);
    // Even/odd split is a left rotate: the top index bit selects the odd half and becomes the LSB.
    always_comb begin
        addr_o = (mode_i == REORDER_BITREV) ? AW'(bit_reverse(32'(rd_idx_i), AW))
                                            : {rd_idx_i[AW-2:0], rd_idx_i[AW-1]};
        odd_o  = (mode_i == REORDER_EVEN_ODD) && rd_idx_i[AW-1];
    end
endmodule

// File: rtl/fft_stream_reorder.sv
// fft_stream_reorder: ping-pong frame buffer replaying each frame in DIT input order
//   clk, reset            : clock, synchronous active-high reset
//   mode                  : replay order, latched with the first sample of each frame
//   in_sample/valid/ready : input sample stream
//   out_sample/valid/ready: reordered output stream
//   out_last              : final sample of an output frame
//   out_odd               : sample comes from the odd half (even/odd mode)
module fft_stream_reorder
    import fft_pkg::*;
#(
    parameter int BUFFER_SIZE = 32,
    parameter int SAMPLE_SIZE = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode,
    input  logic signed [SAMPLE_SIZE-1:0] in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [SAMPLE_SIZE-1:0] out_sample,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          out_odd
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam logic [AW-1:0] LAST = AW'(BUFFER_SIZE - 1);

    logic signed [SAMPLE_SIZE-1:0] bank_q [2][BUFFER_SIZE];
    logic [1:0]    full_q, full_d, mode_q, mode_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_addr;
    logic          in_xfer, out_xfer, rd_odd;

    fft_reorder_addr_gen #(.BUFFER_SIZE(BUFFER_SIZE)) u_addr (
        .rd_idx_i (rd_idx_q),
        .mode_i   (reorder_mode_e'(mode_q[rd_bank_q])),
        .addr_o   (rd_addr),
        .odd_o    (rd_odd)
    );

    assign in_ready   = !full_q[wr_bank_q];
    assign out_valid  = full_q[rd_bank_q];
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign out_last   = out_valid && (rd_idx_q == LAST);
    assign out_odd    = rd_odd;
    // Gated so stale bank contents never reach the output while empty.
    assign out_sample = out_valid ? bank_q[rd_bank_q][rd_addr] : '0;

    // Write and read completions always target different banks, so both updates can land together.
    always_comb begin
        full_d    = full_q;
        mode_d    = mode_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        if (in_xfer) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (wr_idx_q == '0) mode_d[wr_bank_q] = mode;
            if (wr_idx_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        if (out_xfer) begin
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) bank_q[wr_bank_q][wr_idx_q] <= in_sample;
        mode_q <= mode_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
        end
    end
endmodule

// File: tb/tb_fft_stream_reorder.sv
// tb_fft_stream_reorder: directed and randomized checks of the frame reorder buffer
module tb_fft_stream_reorder;
    localparam int N = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, md = 1'b0, ival = 1'b0, ordy = 1'b0;
    logic signed [31:0] isamp = '0, osamp;
    logic irdy, oval, olast, oodd;

    logic rst3 = 1'b1, md3 = 1'b0, ival3 = 1'b0, ordy3 = 1'b0;
    logic signed [31:0] isamp3 = '0, osamp3;
    logic irdy3, oval3, olast3, oodd3;

    fft_stream_reorder #(.BUFFER_SIZE(8), .SAMPLE_SIZE(32)) dut (
        .clk(clk), .reset(rst), .mode(md), .in_sample(isamp), .in_valid(ival), .in_ready(irdy),
        .out_sample(osamp), .out_valid(oval), .out_ready(ordy), .out_last(olast), .out_odd(oodd)
    );

    fft_stream_reorder #(.BUFFER_SIZE(32), .SAMPLE_SIZE(32)) dut32 (
        .clk(clk), .reset(rst3), .mode(md3), .in_sample(isamp3), .in_valid(ival3), .in_ready(irdy3),
        .out_sample(osamp3), .out_valid(oval3), .out_ready(ordy3), .out_last(olast3), .out_odd(oodd3)
    );

    int checks = 0, failures = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        odd;
        logic        last;
    } exp_t;
    exp_t        expq[$];
    logic [31:0] fbuf [N];
    int          wcnt = 0, rcnt = 0, pend = 0;
    logic        fmode = 1'b0;

    function automatic int brev(int r, int aw);
        int v = 0;
        for (int b = 0; b < aw; b++) v = v * 2 + ((r >> b) & 1);
        return v;
    endfunction

    // Position in the stored frame of the k-th output sample.
    function automatic int src(int k, int n, int aw, logic m);
        return m ? brev(k, aw) : (k < n / 2 ? 2 * k : 2 * (k - n / 2) + 1);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; ival = 1'b0; ordy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expq.delete(); wcnt = 0; rcnt = 0; pend = 0;
    endtask

    task automatic write_frame(int base, logic m0, logic m3);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            ival = 1'b1; isamp = base + k; md = (k < 3) ? m0 : m3; ordy = 1'b0;
            #1;
            checks++;
            if (irdy !== 1'b1) begin failures++; $display("FAIL wr_ready k=%0d got=%b exp=1", k, irdy); end
        end
        @(posedge clk);
        #1 ival = 1'b0;
    endtask

    task automatic read_frame(int exp_ord [N], int base, logic m);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            ordy = 1'b1;
            #1;
            checks++;
            if (oval !== 1'b1) begin failures++; $display("FAIL rd_valid k=%0d got=%b exp=1", k, oval); end
            checks++;
            if (osamp !== 32'(base + exp_ord[k])) begin failures++; $display("FAIL rd_sample k=%0d got=%0d exp=%0d", k, osamp, base + exp_ord[k]); end
            checks++;
            if (oodd !== (!m && k >= N / 2)) begin failures++; $display("FAIL rd_odd k=%0d got=%b exp=%b", k, oodd, !m && k >= N / 2); end
            checks++;
            if (olast !== (k == N - 1)) begin failures++; $display("FAIL rd_last k=%0d got=%b exp=%b", k, olast, k == N - 1); end
        end
        @(posedge clk);
        #1 ordy = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (oval !== 1'b0) begin failures++; $display("FAIL rd_empty got=%b exp=0", oval); end
    endtask

    task automatic run_random(int ncyc, int pin, int pout, int mpol);
        logic in_x, out_x;
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            ival  = ($urandom_range(99) < pin);
            isamp = $urandom;
            md    = (mpol == 2) ? 1'($urandom_range(1)) : (mpol == 1);
            ordy  = ($urandom_range(99) < pout);
            #1;
            checks++;
            if (irdy !== (pend < 2)) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, irdy, pend < 2); end
            checks++;
            if (oval !== (pend > 0)) begin failures++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, oval, pend > 0); end
            if (pend > 0 && expq.size() > 0) begin
                checks++;
                if (osamp !== expq[0].s) begin failures++; $display("FAIL rnd_sample c=%0d got=%h exp=%h", c, osamp, expq[0].s); end
                checks++;
                if (oodd !== expq[0].odd) begin failures++; $display("FAIL rnd_odd c=%0d got=%b exp=%b", c, oodd, expq[0].odd); end
                checks++;
                if (olast !== expq[0].last) begin failures++; $display("FAIL rnd_last c=%0d got=%b exp=%b", c, olast, expq[0].last); end
            end
            in_x  = ival && (pend < 2);
            out_x = (pend > 0) && ordy;
            if (out_x) begin
                void'(expq.pop_front());
                rcnt++;
                if (rcnt == N) begin rcnt = 0; pend--; end
            end
            if (in_x) begin
                if (wcnt == 0) fmode = md;
                fbuf[wcnt] = isamp;
                wcnt++;
                if (wcnt == N) begin
                    for (int k = 0; k < N; k++) begin
                        e.s    = fbuf[src(k, N, AW, fmode)];
                        e.odd  = !fmode && k >= N / 2;
                        e.last = (k == N - 1);
                        expq.push_back(e);
                    end
                    pend++;
                    wcnt = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (irdy !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", irdy); end
        checks++;
        if (oval !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", oval); end
        checks++;
        if (olast !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", olast); end
        checks++;
        if (oodd !== 1'b0) begin failures++; $display("FAIL reset_out_odd got=%b exp=0", oodd); end
        checks++;
        if (osamp !== 32'sd0) begin failures++; $display("FAIL reset_out_sample got=%0d exp=0", osamp); end
    endtask

    task automatic test_even_odd();
        write_frame(0, 1'b0, 1'b0);
        read_frame('{0, 2, 4, 6, 1, 3, 5, 7}, 0, 1'b0);
    endtask

    task automatic test_bitrev();
        write_frame(0, 1'b1, 1'b1);
        read_frame('{0, 4, 2, 6, 1, 5, 3, 7}, 0, 1'b1);
    endtask

    task automatic test_mode_change();
        write_frame(0, 1'b1, 1'b0);
        read_frame('{0, 4, 2, 6, 1, 5, 3, 7}, 0, 1'b1);
        write_frame(8, 1'b0, 1'b0);
        read_frame('{0, 2, 4, 6, 1, 3, 5, 7}, 8, 1'b0);
    endtask

    task automatic test_reset_mid();
        write_frame(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ival = 1'b1; isamp = 50 + i; md = 1'b1; ordy = (i < 3);
        end
        @(negedge clk);
        ival = 1'b0; ordy = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (oval !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", oval); end
        checks++;
        if (irdy !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", irdy); end
        checks++;
        if (olast !== 1'b0) begin failures++; $display("FAIL midrst_out_last got=%b exp=0", olast); end
        write_frame(100, 1'b0, 1'b0);
        read_frame('{0, 2, 4, 6, 1, 3, 5, 7}, 100, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_random(120, 100, 100, 0);
        run_random(30, 0, 100, 0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        run_random(24, 100, 0, 1);
        run_random(24, 0, 100, 1);
    endtask

    task automatic test_random();
        apply_reset();
        run_random(3000, 70, 60, 2);
        run_random(40, 0, 100, 0);
    endtask

    task automatic test_n32();
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            ival3 = 1'b1; isamp3 = k; md3 = 1'b0; ordy3 = 1'b1;
        end
        @(posedge clk);
        #1 ival3 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (oval3 !== 1'b1) begin failures++; $display("FAIL n32_valid k=%0d got=%b exp=1", k, oval3); end
            checks++;
            if (osamp3 !== 32'(k < 16 ? 2 * k : 2 * (k - 16) + 1)) begin failures++; $display("FAIL n32_sample k=%0d got=%0d exp=%0d", k, osamp3, k < 16 ? 2 * k : 2 * (k - 16) + 1); end
            checks++;
            if (olast3 !== (k == 31)) begin failures++; $display("FAIL n32_last k=%0d got=%b exp=%b", k, olast3, k == 31); end
        end
        @(negedge clk);
        #1;
        checks++;
        if (oval3 !== 1'b0) begin failures++; $display("FAIL n32_empty got=%b exp=0", oval3); end
    endtask

    initial begin
        test_reset();
        test_even_odd();
        test_bitrev();
        test_mode_change();
        test_reset_mid();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_n32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
